// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state and result-flag types for alu_nway_seq.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } state_e;

    typedef struct packed {
        logic cf;
        logic of;
        logic zf;
        logic nf;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: loads on start_i, one partial
// product per cycle for WIDTH cycles, then holds done_o for one cycle.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == CW'(WIDTH)) begin
                run_q <= 1'b0;
            end else begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
            end
        end
    end

    assign done_o = run_q && (cnt_q == CW'(WIDTH));
    assign prod_o = acc_q;

endmodule

// File: rtl/alu_nway_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides and a one-entry
// result register. Define ALU_MUL_EN to build the iterative MUL (opcode 1011).
module alu_nway_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cf,
    output logic             of,
    output logic             zf,
    output logic             nf,
    output logic             err
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    state_e           state_q;
    logic [WIDTH-1:0] out_q;
    flags_t           flg_q;

    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flg;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    flags_t           mul_flg;

    always_comb begin
        logic [WIDTH:0]   sum;
        logic [SHW-1:0]   sh;
        sum     = '0;
        sh      = b[SHW-1:0];
        alu_res = '0;
        alu_flg = '0;
        case (op)
            OP_ADD: begin
                sum        = {1'b0, a} + {1'b0, b};
                alu_res    = sum[WIDTH-1:0];
                alu_flg.cf = sum[WIDTH];
                alu_flg.of = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res    = a + ~b + WIDTH'(1);
                alu_flg.cf = (a < b);
                alu_flg.of = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_NOT:  alu_res = ~a;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> sh);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MUL_EN
            OP_MUL:  alu_res = '0;
`endif
            default: alu_flg.err = 1'b1;
        endcase
        alu_flg.zf = (alu_res == '0);
        alu_flg.nf = alu_res[MSB];
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (in_valid && in_ready && is_mul),
        .a_i     (a),
        .b_i     (b),
        .done_o  (mul_done),
        .prod_o  (prod)
    );

    assign is_mul  = (op == OP_MUL);
    assign mul_res = prod[WIDTH-1:0];
    always_comb begin
        mul_flg     = '0;
        mul_flg.cf  = |prod[2*WIDTH-1:WIDTH];
        mul_flg.zf  = (mul_res == '0);
        mul_flg.nf  = mul_res[MSB];
    end
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign mul_flg  = '0;
`endif

    assign in_ready = (state_q == IDLE) || ((state_q == FULL) && out_ready);

    // IDLE and FULL share one path: both accept whenever in_ready is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            flg_q   <= '0;
        end else begin
            case (state_q)
                BUSY: begin
                    if (mul_done) begin
                        state_q <= FULL;
                        out_q   <= mul_res;
                        flg_q   <= mul_flg;
                    end
                end
                default: begin
                    if (in_ready) begin
                        if (!in_valid) begin
                            state_q <= IDLE;
                        end else if (is_mul) begin
                            state_q <= BUSY;
                        end else begin
                            state_q <= FULL;
                            out_q   <= alu_res;
                            flg_q   <= alu_flg;
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid = (state_q == FULL);
    assign out       = out_q;
    assign cf        = flg_q.cf;
    assign of        = flg_q.of;
    assign zf        = flg_q.zf;
    assign nf        = flg_q.nf;
    assign err       = flg_q.err;

endmodule

// File: tb/tb_alu_nway_seq.sv
// Scoreboard bench for alu_nway_seq at WIDTH = 8 with hand-computed vectors.
module tb_alu_nway_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       cf, of, zf, nf, err;

    typedef struct {
        logic [7:0] o;
        logic [4:0] f;  // {cf, of, zf, nf, err}
        string      name;
    } exp_t;

    exp_t q[$];
    int   pop_cyc[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    alu_nway_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cf        (cf),
        .of        (of),
        .zf        (zf),
        .nf        (nf),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t mk(input string nm, input logic [7:0] o,
                                input logic c, input logic v, input logic z,
                                input logic n, input logic e);
        exp_t r;
        r.o = o;
        r.f = {c, v, z, n, e};
        r.name = nm;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got out=%h with no result expected", out);
            end else begin
                e = q.pop_front();
                pop_cyc.push_back(cyc);
                vectors++;
                if ({out, cf, of, zf, nf, err} !== {e.o, e.f}) begin
                    miscompares++;
                    $display("FAIL %s: got out=%h cf/of/zf/nf/err=%b expected out=%h cf/of/zf/nf/err=%b",
                             e.name, out, {cf, of, zf, nf, err}, e.o, e.f);
                end
            end
        end
    end

    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input exp_t e, input bit push);
        int n;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk({e.name, "_accept_timeout"}, 16'(in_ready), 16'd1);
        if (push) q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a = '0;
        b = '0;
        #2;
        chk("reset_out_valid", 16'(out_valid), 16'd0);
        chk("reset_out", 16'(out), 16'd0);
        chk("reset_flags", 16'({cf, of, zf, nf, err}), 16'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 16'(in_ready), 16'd1);

        send(4'b0000, 8'h7F, 8'h01, mk("add_ovf",   8'h80, 0, 1, 0, 1, 0), 1);
        send(4'b0001, 8'h00, 8'h01, mk("sub_borrow",8'hFF, 1, 0, 0, 1, 0), 1);
        send(4'b0001, 8'h80, 8'h01, mk("sub_ovf",   8'h7F, 0, 1, 0, 0, 0), 1);
        send(4'b0110, 8'h80, 8'h01, mk("slt",       8'h01, 0, 0, 0, 0, 0), 1);
        send(4'b1100, 8'h80, 8'h01, mk("sltu",      8'h00, 0, 0, 1, 0, 0), 1);
        send(4'b0000, 8'hFF, 8'h01, mk("add_carry", 8'h00, 1, 0, 1, 0, 0), 1);
        send(4'b0011, 8'hF0, 8'h3C, mk("and",       8'h30, 0, 0, 0, 0, 0), 1);
        send(4'b0100, 8'hF0, 8'h0F, mk("or",        8'hFF, 0, 0, 0, 1, 0), 1);
        send(4'b0101, 8'hAA, 8'hFF, mk("xor",       8'h55, 0, 0, 0, 0, 0), 1);
        send(4'b0010, 8'h0F, 8'h00, mk("not",       8'hF0, 0, 0, 0, 1, 0), 1);
        send(4'b0111, 8'h5A, 8'h5A, mk("eq_true",   8'h01, 0, 0, 0, 0, 0), 1);
        send(4'b0111, 8'h5A, 8'h5B, mk("eq_false",  8'h00, 0, 0, 1, 0, 0), 1);
        send(4'b1000, 8'h81, 8'h09, mk("sll_mask",  8'h02, 0, 0, 0, 0, 0), 1);
        send(4'b1001, 8'h81, 8'h03, mk("srl",       8'h10, 0, 0, 0, 0, 0), 1);
        send(4'b1010, 8'h81, 8'h03, mk("sra",       8'hF0, 0, 0, 0, 1, 0), 1);
        send(4'b1110, 8'hFF, 8'hFF, mk("illegal_1110", 8'h00, 0, 0, 1, 0, 1), 1);
        send(4'b0000, 8'h01, 8'h02, mk("add_clears_err", 8'h03, 0, 0, 0, 0, 0), 1);
        idle(2);

`ifdef ALU_MUL_EN
        send(4'b1011, 8'h10, 8'h11, mk("mul", 8'h10, 1, 0, 0, 0, 0), 1);
        in_valid = 1'b0;
        op = 4'b0000;
        a = 8'hFF;
        b = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("mul_busy_out_valid", 16'(out_valid), 16'd0);
            chk("mul_busy_in_ready", 16'(in_ready), 16'd0);
        end
        @(negedge clk);
        chk("mul_latency_out_valid", 16'(out_valid), 16'd1);
        @(posedge clk);
        #1;
`else
        send(4'b1011, 8'h10, 8'h11, mk("illegal_1011", 8'h00, 0, 0, 1, 0, 1), 1);
        send(4'b0001, 8'h05, 8'h03, mk("sub_clears_err", 8'h02, 0, 0, 0, 0, 0), 1);
        idle(2);
`endif

        out_ready = 1'b0;
        send(4'b0101, 8'h0F, 8'hF0, mk("xor_held", 8'hFF, 0, 0, 0, 1, 0), 1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 16'(out_valid), 16'd1);
            chk("bp_out", 16'(out), 16'hFF);
            chk("bp_flags", 16'({cf, of, zf, nf, err}), 16'b00010);
            chk("bp_in_ready", 16'(in_ready), 16'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        pop_cyc.delete();
        send(4'b0000, 8'h01, 8'h01, mk("stream0", 8'h02, 0, 0, 0, 0, 0), 1);
        send(4'b0000, 8'h10, 8'h20, mk("stream1", 8'h30, 0, 0, 0, 0, 0), 1);
        send(4'b0000, 8'h7F, 8'h7F, mk("stream2", 8'hFE, 0, 1, 0, 1, 0), 1);
        send(4'b0000, 8'h80, 8'h80, mk("stream3", 8'h00, 1, 1, 1, 0, 0), 1);
        in_valid = 1'b0;
        n = 0;
        while (pop_cyc.size() < 4 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("stream_count", 16'(pop_cyc.size()), 16'd4);
        if (pop_cyc.size() >= 4) begin
            for (int i = 1; i < 4; i++) chk("stream_consecutive", 16'(pop_cyc[i] - pop_cyc[i-1]), 16'd1);
        end
        @(posedge clk);
        #1;

`ifdef ALU_MUL_EN
        send(4'b1011, 8'h03, 8'h05, mk("mul_discarded", 8'h0F, 0, 0, 0, 0, 0), 0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
`else
        out_ready = 1'b0;
        send(4'b0011, 8'hFF, 8'h3C, mk("and_discarded", 8'h3C, 0, 0, 0, 0, 0), 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_out", 16'(out), 16'h3C);
        @(posedge clk);
        #1;
`endif
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 16'(out_valid), 16'd0);
        chk("midreset_out", 16'(out), 16'd0);
        chk("midreset_flags", 16'({cf, of, zf, nf, err}), 16'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("postreset_in_ready", 16'(in_ready), 16'd1);
        n = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("postreset_no_result", 16'(n), 16'd0);
        @(posedge clk);
        #1;
        send(4'b0000, 8'h05, 8'h03, mk("add_after_reset", 8'h08, 0, 0, 0, 0, 0), 1);
        in_valid = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("drain_pending", 16'(q.size()), 16'd0);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_nway_seq.md
# alu_nway_seq

Parametrised, registered successor to the 4-bit combinational ALU: WIDTH-bit operands, a 4-bit opcode (the original 8 operations plus shifts, unsigned compare and an optional iterative multiply), and proper two's-complement subtract. It has a valid/ready handshake on both sides and a one-entry result register. It sits between the decode stage and writeback in the NPC datapath and absorbs writeback back-pressure.

## Interface
- WIDTH, default 32: operand/result width. Must be a power of two, ≥ 4.
- SHW, default $clog2(WIDTH): shift-amount width (derived; not overridden).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  opcode.
- a, b  in  WIDTH  operands; sampled only on acceptance.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  result.
- cf, of, zf, nf  out  1 each  carry/borrow, signed overflow, zero, negative.
- err  out  1  illegal opcode was executed.

## Operation
- Acceptance: a request is accepted on the edge where in_valid && in_ready. Transfer out happens on the edge where out_valid && out_ready.
- Opcodes:
  - 0000 ADD.
  - 0001 SUB: a + ~b + 1.
  - 0010 NOT a.
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
  - 0110 SLT, signed.
  - 0111 EQ.
  - 1000 SLL.
  - 1001 SRL.
  - 1010 SRA.
  - 1011 MUL.
  - 1100 SLTU.
  - 1101–1111 illegal.
- Shifts use b[SHW-1:0] only. Compares produce 1 or 0, zero-extended.
- ADD flags: cf = carry out of bit WIDTH-1; of = (a[msb]==b[msb]) && (out[msb]!=a[msb]).
- SUB flags: cf = borrow (a < b unsigned); of = (a[msb]!=b[msb]) && (out[msb]!=a[msb]).
- MUL: out = low WIDTH bits of the unsigned product; cf = 1 if any of the upper WIDTH bits is nonzero; of = 0.
- All other ops: cf = of = 0.
- All ops: zf = (out == 0); nf = out[WIDTH-1].
- Illegal opcode: out = 0, cf = of = nf = 0, zf = 1, err = 1. err = 0 for every legal op.
- State machine IDLE / BUSY / FULL:
  - IDLE: in_ready = 1. On accepting a single-cycle op → FULL. On accepting MUL → BUSY.
  - BUSY: in_ready = 0; the iteration counter runs WIDTH cycles, then → FULL.
  - FULL: out_valid = 1; in_ready = out_ready.
    - Transfer with no new request → IDLE.
    - Transfer with a single-cycle request → stay FULL, loading the new result.
    - Transfer with MUL → BUSY.
- Operands and op are latched on acceptance. Changes to a, b or op during BUSY have no effect.
- Outputs out, flags and err are stable while out_valid && !out_ready.

## Timing
- Reset values: state = IDLE; out_valid = 0; out = 0; cf = of = nf = err = 0; zf = 0; counter = 0. in_ready = 1 once rst_n deasserts.
- Reset mid-MUL: the operation is discarded and no result is ever presented.
- Single-cycle op accepted at edge 0: out_valid = 1 from edge 1.
- Throughput is 1 op/cycle while out_ready = 1.
- MUL accepted at edge 0: BUSY after edges 1..WIDTH; out_valid = 1 after edge WIDTH+1. in_ready = 0 throughout.
- Every output is registered. in_ready is combinational from state and out_ready only; there is no path from in_valid.

## Configuration
- ALU_MUL_EN defined: opcode 1011 is MUL as described, and the BUSY state plus the multiplier are built.
- ALU_MUL_EN undefined:
  - 1011 is an illegal opcode, completing in one cycle with err = 1.
  - BUSY is unreachable and the multiplier is not instantiated.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_SLTU);
  - the state enum {IDLE, BUSY, FULL};
  - a flags struct {cf, of, zf, nf, err}.
- One sub-module, alu_mul_iter: shift-add unsigned multiplier, WIDTH iterations, with start/done and a 2·WIDTH product. Instantiated only under ALU_MUL_EN.
- The combinational single-cycle datapath is a function or always_comb block in the top module.

## Test plan
All scenarios use WIDTH = 8.
- ADD 8'h7F + 8'h01 accepted at edge 0 → after edge 1: out = 8'h80, of = 1, nf = 1, cf = 0, zf = 0, out_valid = 1.
- SUB 8'h00 − 8'h01 → out = 8'hFF, cf = 1, of = 0. SUB 8'h80 − 8'h01 → out = 8'h7F, of = 1. SLT 8'h80, 8'h01 → 1; SLTU 8'h80, 8'h01 → 0.
- MUL 8'h10 × 8'h11 (ALU_MUL_EN) → out_valid rises exactly 9 edges after acceptance with out = 8'h10, cf = 1; in_ready = 0 during BUSY; changing a/b mid-op has no effect.
- Back-pressure: out_ready held low 3 cycles after an XOR result → out and flags stable, in_ready = 0. Then stream 4 ADDs with out_ready = 1 → 4 results on consecutive cycles, in order.
- rst_n pulsed low at BUSY cycle 4 of a MUL → out_valid = 0 and all outputs 0 immediately; no result appears afterwards; the next ADD completes normally.
- Opcode 4'b1110 (and 4'b1011 without ALU_MUL_EN) → one-cycle latency, out = 0, zf = 1, err = 1. The following legal op clears err.
